// File: rtl/vend_dispense_arbiter.sv
// vend_dispense_arbiter
// Shares one dispense motor and one change hopper among N_LANES vending-lane
// FSMs. Waiting lanes are granted round-robin. The arbiter runs the motor for
// MOTOR_CYCLES cycles, then runs the hopper for CHANGE_CYCLES cycles if the
// lane owes change. It then returns a one-cycle ack to that lane.
//
// Ports:
//   sys_clk    rising-edge clock
//   sysRstN    asynchronous active-low reset
//   reqVend    per-lane dispense request, held until the lane's ack
//   reqChange  per-lane change-owed flag, sampled at grant
//   ackVend    one-hot, one-cycle completion pulse
//   motorOn    shared dispense motor enable
//   motorSel   one-hot chute select, nonzero only while motorOn
//   hopperOn   change hopper enable
//   busy       high whenever the arbiter is not idle
//
// Optional build macro VEND_JAM_DETECT_EN adds the following:
//   dropSense  product-drop sensor pulse input
//   jamErr     sticky jam flag output; while it is set no further grants are made
module vend_dispense_arbiter #(
  parameter int N_LANES       = 4,
  parameter int MOTOR_CYCLES  = 8,
  parameter int CHANGE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic               sys_clk,
  input  logic               sysRstN,
  input  logic [N_LANES-1:0] reqVend,
  input  logic [N_LANES-1:0] reqChange,
`ifdef VEND_JAM_DETECT_EN
  input  logic               dropSense,
  output logic               jamErr,
`endif
  output logic [N_LANES-1:0] ackVend,
  output logic               motorOn,
  output logic [N_LANES-1:0] motorSel,
  output logic               hopperOn,
  output logic               busy
);

  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(N_LANES - 1);

  typedef enum logic [1:0] {IDLE, MOTOR, CHANGE, ACK} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] idx;
  logic             found;
  logic             chg_flag;
  logic [CNT_W-1:0] cnt;
  logic             vend_good;
  logic             jam_block;

`ifdef VEND_JAM_DETECT_EN
  logic drop_seen;

  // A drop pulse in the final motor cycle still counts as a good vend.
  assign vend_good = drop_seen | dropSense;
  assign jam_block = jamErr;
`else
  assign vend_good = 1'b1;
  assign jam_block = 1'b0;
`endif

  function automatic logic [N_LANES-1:0] onehot(input logic [PTR_W-1:0] lane);
    logic [N_LANES-1:0] v;
    v       = '0;
    v[lane] = 1'b1;
    return v;
  endfunction

  // Round-robin search. Start at rr_ptr, walk upward with wrap, and take the
  // first requesting lane.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = rr_ptr;
    for (int i = 0; i < N_LANES; i++) begin
      if (!found && reqVend[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == LAST_LANE) ? '0 : idx + 1'b1;
    end
  end

  // Sequencer with registered actuator outputs. The grant, the change flag
  // and the duration counter are latched when a lane is granted. Later
  // request activity has no effect until the arbiter returns to IDLE.
  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      chg_flag <= 1'b0;
      cnt      <= '0;
      ackVend  <= '0;
      motorOn  <= 1'b0;
      motorSel <= '0;
      hopperOn <= 1'b0;
      busy     <= 1'b0;
`ifdef VEND_JAM_DETECT_EN
      drop_seen <= 1'b0;
      jamErr    <= 1'b0;
`endif
    end else begin
      ackVend <= '0;
      case (state)
        IDLE: begin
          if (found && !jam_block) begin
            grant    <= pick;
            chg_flag <= reqChange[pick];
            cnt      <= CNT_W'(MOTOR_CYCLES - 1);
            motorOn  <= 1'b1;
            motorSel <= onehot(pick);
            busy     <= 1'b1;
            state    <= MOTOR;
`ifdef VEND_JAM_DETECT_EN
            drop_seen <= 1'b0;
`endif
          end
        end
        MOTOR: begin
`ifdef VEND_JAM_DETECT_EN
          drop_seen <= drop_seen | dropSense;
          if (cnt == '0 && !vend_good) jamErr <= 1'b1;
`endif
          if (cnt == '0) begin
            motorOn  <= 1'b0;
            motorSel <= '0;
            // A jammed vend skips the change payout but is still acknowledged.
            if (chg_flag && vend_good) begin
              cnt      <= CNT_W'(CHANGE_CYCLES - 1);
              hopperOn <= 1'b1;
              state    <= CHANGE;
            end else begin
              ackVend <= onehot(grant);
              state   <= ACK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHANGE: begin
          if (cnt == '0) begin
            hopperOn <= 1'b0;
            ackVend  <= onehot(grant);
            state    <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          busy   <= 1'b0;
          rr_ptr <= (grant == LAST_LANE) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: begin
          motorOn  <= 1'b0;
          motorSel <= '0;
          hopperOn <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
